// File: rtl/window_gen_3x3_if.sv
// Stream-side bundle for window_gen_3x3: pixel input handshake and window output handshake.
// Optional WIN_COORD_EN adds the window-centre coordinate outputs.
interface window_gen_3x3_if #(
    parameter int PIX_W = 8
`ifdef WIN_COORD_EN
    , parameter int XW = 6
    , parameter int YW = 6
`endif
);
    logic                        in_valid;
    logic                        in_ready;
    logic [PIX_W-1:0]            in_pix;
    logic [0:2][0:2][PIX_W:0]    img;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;
`ifdef WIN_COORD_EN
    logic [XW-1:0]               out_x;
    logic [YW-1:0]               out_y;

    modport master (output in_valid, in_pix, out_ready,
                    input  in_ready, img, out_valid, out_last, out_x, out_y);
    modport slave  (input  in_valid, in_pix, out_ready,
                    output in_ready, img, out_valid, out_last, out_x, out_y);
`else
    modport master (output in_valid, in_pix, out_ready,
                    input  in_ready, img, out_valid, out_last);
    modport slave  (input  in_valid, in_pix, out_ready,
                    output in_ready, img, out_valid, out_last);
`endif
endinterface

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator with two line memories and a one-slot output register.
// Define WIN_COORD_EN to also output the window-centre coordinates (out_x/out_y).
module window_gen_3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    window_gen_3x3_if.slave   bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]               r_state;
    logic [XW-1:0]            r_x;
    logic [YW-1:0]            r_y;
    logic [PIX_W-1:0]         r_line0 [IMG_W];
    logic [PIX_W-1:0]         r_line1 [IMG_W];
    logic [0:2][0:2][PIX_W:0] r_win;
    logic                     r_out_valid;
    logic                     r_out_last;

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_x_last;
    logic                     w_y_last;
    logic                     w_emit;
    logic [PIX_W-1:0]         w_l0;
    logic [PIX_W-1:0]         w_l1;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_x_last   = (r_x == XW'(IMG_W - 1));
    assign w_y_last   = (r_y == YW'(IMG_H - 1));
    assign w_emit     = w_accept && (r_state == S_RUN) && (r_x >= XW'(2));
    assign w_l0       = r_line0[r_x];
    assign w_l1       = r_line1[r_x];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
            r_x     <= '0;
            r_y     <= '0;
        end else if (w_accept) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + YW'(1);
                if (r_state == S_FILL && r_y == YW'(1))
                    r_state <= S_RUN;
                else if (r_state == S_RUN && w_y_last)
                    r_state <= S_FILL;
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    // Line memories carry no reset; every entry is rewritten before a window can expose it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line1[r_x] <= w_l0;
            r_line0[r_x] <= bus.in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= {1'b0, w_l1};
                r_win[1][2] <= {1'b0, w_l0};
                r_win[2][2] <= {1'b0, bus.in_pix};
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_x_last && w_y_last;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef WIN_COORD_EN
    logic [XW-1:0] r_out_x;
    logic [YW-1:0] r_out_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_x <= '0;
            r_out_y <= '0;
        end else if (w_emit) begin
            r_out_x <= r_x - XW'(1);
            r_out_y <= r_y - YW'(1);
        end
    end

    assign bus.out_x = r_out_x;
    assign bus.out_y = r_out_y;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.img       = r_win;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 4x4 image: ramp frames, stalls, gaps, resets.
module tb_window_gen_3x3;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;

    typedef logic [0:2][0:2][PW:0] win_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef WIN_COORD_EN
    window_gen_3x3_if #(.PIX_W(PW), .XW(2), .YW(2)) bus ();
`else
    window_gen_3x3_if #(.PIX_W(PW)) bus ();
`endif

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    win_t q_win[$];
    logic q_last[$];

    // A window counts as delivered when valid and ready are both high at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            q_win.push_back(bus.img);
            q_last.push_back(bus.out_last);
        end
    end

    function automatic win_t exp_win(int base, int k, bit hi255);
        win_t w;
        int cy, cx, py, px, p;
        cy = 1 + k / 2;
        cx = 1 + k % 2;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                py = cy - 1 + r;
                px = cx - 1 + c;
                p  = (hi255 && py == 3 && px == 3) ? 255 : base + 4 * py + px;
                w[r][c] = 9'(p);
            end
        return w;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_win(input string tag, input win_t obs, input win_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_pix(input logic [PW-1:0] p);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_pix   = p;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: got no in_ready expected in_ready within 50 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit hi255, input bit gap, input bit lat);
        int p;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                p = (hi255 && y == 3 && x == 3) ? 255 : base + 4 * y + x;
                send_pix(PW'(p));
                if (lat && y == 2 && x == 1) check_bit("no_window_at_x1", bus.out_valid, 1'b0);
                if (lat && y == 2 && x == 2) begin
                    check_bit("first_latency", bus.out_valid, 1'b1);
                    check_win("first_latency_img", bus.img, exp_win(0, 0, 1'b0));
                end
                if (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
    endtask

    task automatic check_frame(input string tag, input int first, input int base, input bit hi255);
        if (q_win.size() >= first + 4)
            for (int k = 0; k < 4; k++) begin
                check_win({tag, "_img"}, q_win[first+k], exp_win(base, k, hi255));
                check_bit({tag, "_last"}, q_last[first+k], k == 3);
            end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    win_t c_first, c_last, f2_first;

    initial begin
        c_first  = {9'd0, 9'd1, 9'd2, 9'd4, 9'd5, 9'd6, 9'd8, 9'd9, 9'd10};
        c_last   = {9'd5, 9'd6, 9'd7, 9'd9, 9'd10, 9'd11, 9'd13, 9'd14, 9'd15};
        f2_first = {9'd100, 9'd101, 9'd102, 9'd104, 9'd105, 9'd106, 9'd108, 9'd109, 9'd110};
        bus.in_valid  = 1'b0;
        bus.in_pix    = '0;
        bus.out_ready = 1'b1;

        // Power-on reset state
        #12;
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check_bit("rst_out_last", bus.out_last, 1'b0);
        check_bit("rst_in_ready", bus.in_ready, 1'b1);
        check_win("rst_img", bus.img, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous ramp
        q_win.delete(); q_last.delete();
        send_frame(0, 1'b0, 1'b0, 1'b1);
        settle();
        check_int("cont_count", q_win.size(), 4);
        if (q_win.size() == 4) begin
            check_win("cont_first_const", q_win[0], c_first);
            check_win("cont_last_const", q_win[3], c_last);
        end
        check_frame("cont", 0, 0, 1'b0);

        // Backpressure right after the first window
        q_win.delete(); q_last.delete();
        bus.out_ready = 1'b0;
        for (int p = 0; p <= 10; p++) send_pix(PW'(p));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("bp_in_ready", bus.in_ready, 1'b0);
            check_bit("bp_out_valid", bus.out_valid, 1'b1);
            check_win("bp_img_hold", bus.img, c_first);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int p = 11; p <= 15; p++) send_pix(PW'(p));
        settle();
        check_int("bp_count", q_win.size(), 4);
        check_frame("bp", 0, 0, 1'b0);

        // Source gaps on every other cycle
        q_win.delete(); q_last.delete();
        send_frame(0, 1'b0, 1'b1, 1'b0);
        settle();
        check_int("gap_count", q_win.size(), 4);
        check_frame("gap", 0, 0, 1'b0);

        // Back-to-back frames, second one offset by 100 with 255 in the corner
        q_win.delete(); q_last.delete();
        send_frame(0, 1'b0, 1'b0, 1'b0);
        send_frame(100, 1'b1, 1'b0, 1'b0);
        settle();
        check_int("b2b_count", q_win.size(), 8);
        check_frame("b2b_f1", 0, 0, 1'b0);
        check_frame("b2b_f2", 4, 100, 1'b1);
        if (q_win.size() == 8) begin
            check_win("b2b_f2_first_const", q_win[4], f2_first);
            check_int("b2b_pix255", int'(q_win[7][2][2]), 9'h0FF);
        end

        // Asynchronous reset while the last window is stalled
        q_win.delete(); q_last.delete();
        for (int p = 0; p <= 15; p++) send_pix(PW'(p));
        bus.out_ready = 1'b0;
        #2;
        check_bit("pre_rst_out_valid", bus.out_valid, 1'b1);
        check_bit("pre_rst_out_last", bus.out_last, 1'b1);
        check_bit("pre_rst_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check_bit("arst_out_valid", bus.out_valid, 1'b0);
        check_bit("arst_out_last", bus.out_last, 1'b0);
        check_bit("arst_in_ready", bus.in_ready, 1'b1);
        check_win("arst_img", bus.img, '0);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset after 7 pixels discards the partial frame
        q_win.delete(); q_last.delete();
        for (int p = 0; p < 7; p++) send_pix(PW'(p));
        #2;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(0, 1'b0, 1'b0, 1'b0);
        settle();
        check_int("midrst_count", q_win.size(), 4);
        check_frame("midrst", 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3×3 neighbourhood generator that sits in front of the sharpening convolution stage. It accepts a raster-order pixel stream, one pixel per accepted beat, and buffers the two previous image rows in line memories. For every interior pixel it presents the full 3×3 window in the same `img[0:2][0:2]` form the sharpening stage consumes. Valid-ready handshakes on both sides let the convolution pipeline stall the source.

## Interface
- `IMG_W`, 64, pixels per row; must be ≥ 3.
- `IMG_H`, 64, rows per frame; must be ≥ 3.
- `PIX_W`, 8, input pixel width; window elements are `PIX_W+1` bits.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_pix` is valid.
- `in_ready`  out  1  block can accept a pixel this cycle.
- `in_pix`  in  `PIX_W`  unsigned pixel, raster order, row 0 first.
- `img[0:2][0:2]`  out  `PIX_W+1` each  window; `[r][c]`, where r=0 is the oldest row and c=0 is the leftmost column.
- `out_valid`  out  1  `img` holds a valid window.
- `out_ready`  in  1  consumer takes the window this cycle.
- `out_last`  out  1  the window is the last one of the frame; qualified by `out_valid`.

## Operation
- A pixel is accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and gives one output slot of buffering.
- Column counter `x` (0..`IMG_W`-1) and row counter `y` (0..`IMG_H`-1) hold the position of the next pixel to be accepted.
  - `x` wraps at `IMG_W`-1 and increments `y`.
  - `y` wraps at `IMG_H`-1, which starts a new frame. No sof/eof input is used.
- Line memories: `line0` holds row y-1 and `line1` holds row y-2, each `IMG_W`×`PIX_W`. On accept at column x:
  - The window shifts left one column.
  - The new column 2 is loaded as {`line1[x]`, `line0[x]`, `in_pix`}, top to bottom, each zero-extended with a leading `1'b0`.
  - `line1[x]` ← `line0[x]`, and `line0[x]` ← `in_pix`.
- Line memories are not reset. Their contents are never visible before being overwritten in the current frame.
- State machine:
  - FILL: y < 2; no windows are produced.
  - RUN: y ≥ 2.
  - Transitions: FILL→RUN on accepting the last pixel of row 1. RUN→FILL on accepting the last pixel of the frame.
- Window emission: accepting pixel (y, x) with y ≥ 2 and x ≥ 2 sets `out_valid` on the next cycle.
  - The window is centred at (y-1, x-1).
  - `out_last` = 1 if (y, x) = (`IMG_H`-1, `IMG_W`-1).
- Windows per frame = (`IMG_W`-2)·(`IMG_H`-2). No border padding.
- `out_valid` clears when the window is taken and the same cycle's accept does not emit a new window.
- Holding: while `out_valid && !out_ready`, `img`, `out_last` and all counters hold, and `in_ready` = 0.
- Row wrap: columns 0 and 1 of the window hold stale pixels from the previous row. This is harmless because no window is emitted at x < 2.

## Timing
- Reset values: `out_valid` = 0, `out_last` = 0, all `img` elements = 0, `x` = `y` = 0, state FILL. `in_ready` = 1 after reset.
- Latency: accept edge → `out_valid` high 1 cycle later.
- Throughput: 1 pixel per cycle when `out_ready` is held high.
- Reset mid-frame: the partial frame is discarded, and the next accepted pixel is (0, 0).
- Simultaneous consume and accept in one cycle: the new window replaces the old one with no bubble.

## Configuration
- `WIN_COORD_EN` defined:
  - Adds output ports `out_x` (`$clog2(IMG_W)` bits) and `out_y` (`$clog2(IMG_H)` bits).
  - They carry the window centre coordinates, registered with `img`, reset to 0, and held under stall.
- `WIN_COORD_EN` undefined: the ports and their registers do not exist. All other behaviour is identical.

## Test plan
All scenarios use `IMG_W` = `IMG_H` = 4 and ramp pixels p = 4y + x unless stated otherwise.
- **Reset values:** assert `rst_n` = 0 mid-stream → `out_valid` = 0, `out_last` = 0, all `img` = 0 and `in_ready` = 1 immediately, without waiting for a clock edge.
- **Continuous ramp, `out_ready` = 1:**
  - Exactly 4 windows are produced.
  - First window, one cycle after pixel 10 is accepted: {{0,1,2},{4,5,6},{8,9,10}}.
  - Last window: {{5,6,7},{9,10,11},{13,14,15}} with `out_last` = 1.
- **Backpressure:** drop `out_ready` for 5 cycles after the first window → `in_ready` = 0 and `img` stable throughout; after release the remaining 3 windows match the continuous case.
- **Source gaps:** `in_valid` deasserted on every other cycle → the same 4 windows in the same order.
- **Back-to-back frames:** a second frame with p = 4y + x + 100, including pixel 255 at (3,3):
  - First window of frame 2 is {{100,101,102},{104,105,106},{108,109,110}}.
  - The element holding 255 reads 9'h0FF.
- **Reset mid-frame:** reset after 7 pixels, then a full ramp frame → the 4 windows are exactly those of the continuous case.
